// File: rtl/adder_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_measure_ctrl
// Brief    : Sequences one adder measurement: apply operands, settle, capture
//            the sum, then count ring-oscillator edges over a clock window.
// Revision : 1.0
// ============================================================================
module adder_measure_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int WIN_W         = 16,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [WIN_W-1:0] cmd_window,
  output logic [31:0]      adder_a,
  output logic [31:0]      adder_b,
  output logic             ring_en,
  input  logic             ring_osc,
  input  logic [31:0]      adder_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [31:0]      res_sum,
  output logic             res_overflow,
  output logic             busy
);

  localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_SETTLE  = 2'd1;
  localparam logic [1:0] c_ST_MEASURE = 2'd2;
  localparam logic [1:0] c_ST_DONE    = 2'd3;

  logic [1:0]             r_state;
  logic [c_SET_W-1:0]     r_settle_cnt;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ring_prev;
  logic [31:0]            r_adder_a;
  logic [31:0]            r_adder_b;
  logic [CNT_W-1:0]       r_res_count;
  logic [31:0]            r_res_sum;
  logic                   r_res_overflow;

  logic w_ring_sync;
  logic w_ring_rise;

  assign w_ring_sync = r_sync[SYNC_STAGES-1];
  assign w_ring_rise = w_ring_sync & ~r_ring_prev;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state        <= c_ST_IDLE;
      r_settle_cnt   <= '0;
      r_win_cnt      <= '0;
      r_sync         <= '0;
      r_ring_prev    <= 1'b0;
      r_adder_a      <= '0;
      r_adder_b      <= '0;
      r_res_count    <= '0;
      r_res_sum      <= '0;
      r_res_overflow <= 1'b0;
    end else begin
      // The synchronizer runs in every state so the edge detector is primed
      // with the current ring level when the window opens.
      r_sync      <= {r_sync[SYNC_STAGES-2:0], ring_osc};
      r_ring_prev <= w_ring_sync;

      case (r_state)
        c_ST_IDLE: begin
          if (cmd_valid) begin
            r_adder_a      <= cmd_a;
            r_adder_b      <= cmd_b;
            r_win_cnt      <= cmd_window;
            r_res_count    <= '0;
            r_res_overflow <= 1'b0;
            r_settle_cnt   <= c_SET_LAST;
            r_state        <= c_ST_SETTLE;
          end
        end

        c_ST_SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_res_sum <= adder_sum;
            r_state   <= (r_win_cnt == '0) ? c_ST_DONE : c_ST_MEASURE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end

        c_ST_MEASURE: begin
          if (w_ring_rise) begin
            if (&r_res_count) begin
              r_res_overflow <= 1'b1;
            end else begin
              r_res_count <= r_res_count + 1'b1;
            end
          end
          if (r_win_cnt <= WIN_W'(1)) begin
            r_state <= c_ST_DONE;
          end
          if (r_win_cnt != '0) begin
            r_win_cnt <= r_win_cnt - 1'b1;
          end
        end

        c_ST_DONE: begin
          if (res_ready) begin
            r_state <= c_ST_IDLE;
          end
        end

        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == c_ST_IDLE);
  assign busy         = ~cmd_ready;
  assign ring_en      = (r_state == c_ST_MEASURE);
  assign res_valid    = (r_state == c_ST_DONE);
  assign adder_a      = r_adder_a;
  assign adder_b      = r_adder_b;
  assign res_count    = r_res_count;
  assign res_sum      = r_res_sum;
  assign res_overflow = r_res_overflow;

endmodule
`default_nettype wire

// File: doc/adder_measure_ctrl.md
Name: adder_measure_ctrl

Overview:
Measurement sequencer that drives an instrumented adder under test.
- Accepts a command holding two operands and a measurement window.
- Applies the operands and lets the adder settle, then captures the sum.
- Enables the adder's ring oscillator for a fixed number of clocks and counts its synchronized rising edges.
- Returns count, sum and overflow on a valid/ready result port.
- Sits between the logic-analyzer register bank (command source, result sink) and the wrapped adder core.

Parameters:
- SETTLE_CYCLES, 4: clocks operands are held with ring disabled before sum capture (must be ≥1).
- WIN_W, 16: width of measurement window field.
- CNT_W, 16: width of edge counter.
- SYNC_STAGES, 2: flops in ring_osc synchronizer (≥2).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle, command accepted when valid&ready.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_window  in  WIN_W  measurement window, in clocks.
- adder_a  out  32  operand A to adder.
- adder_b  out  32  operand B to adder.
- ring_en  out  1  ring oscillator enable.
- ring_osc  in  1  asynchronous ring oscillator tap.
- adder_sum  in  32  adder sum output.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when valid&ready.
- res_count  out  CNT_W  rising edges counted in window.
- res_sum  out  32  captured sum.
- res_overflow  out  1  edge counter saturated.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SETTLE, MEASURE, DONE.
- Reset values (asserted asynchronously): state=IDLE, cmd_ready=1, busy=0, ring_en=0, res_valid=0, adder_a=0, adder_b=0, res_count=0, res_sum=0, res_overflow=0, synchronizer=0, counters=0.
- Reset mid-operation: immediate return to reset values; no result is produced.
- cmd_ready = (state==IDLE); busy = !cmd_ready.
- Command accept: cmd_valid&cmd_ready in cycle T.
  - Registers adder_a/adder_b from cmd_a/cmd_b and latches cmd_window.
  - Clears res_count and res_overflow.
  - Goes to SETTLE.
- SETTLE occupies cycles T+1..T+SETTLE_CYCLES with ring_en=0.
  - adder_sum is sampled into res_sum on the last SETTLE cycle.
  - Next state is MEASURE, or DONE if the latched window==0 (ring_en is never asserted in that case).
- MEASURE occupies exactly W cycles, T+SETTLE_CYCLES+1..T+SETTLE_CYCLES+W, with ring_en=1.
- Edge counting:
  - ring_osc passes through SYNC_STAGES flops; a rising edge is synchronized&!previous_synchronized.
  - Each detected edge in a MEASURE cycle increments res_count.
  - At all-ones the count holds and res_overflow is set (sticky until the next accept).
  - Edges are ignored outside MEASURE.
- DONE:
  - Entered at T+SETTLE_CYCLES+W+1, with res_valid=1 and ring_en=0.
  - res_count, res_sum and res_overflow are stable while res_valid=1.
  - On res_valid&res_ready, goes to IDLE next cycle; cmd_ready rises that cycle.
  - A command offered in the same cycle as res_ready is not accepted.
- adder_a/adder_b hold their last values after DONE; they change only on accept.
- cmd_* inputs are ignored outside IDLE.
- Window counter: WIN_W bits, decrementing, no wrap.

Test Plan:
- Reset: assert wb_rst_i mid-MEASURE -> ring_en=0, res_valid=0, cmd_ready=1 in the same cycle; res_count=0 after release.
- Sum capture: cmd_a=0x0000_0040, cmd_b=0x0000_00C0, window=8, adder model sum=a+b -> res_sum=0x0000_0100; res_valid at accept+13 (SETTLE=4).
- Counting: ring_osc free-running with period 4 clocks, window=16 -> res_count=4, res_overflow=0; ring_en high exactly 16 cycles.
- Saturation: CNT_W=4, ring_osc period 2 clocks, window=40 -> res_count=15, res_overflow=1.
- Zero window: window=0 -> ring_en never high, res_count=0, res_valid at accept+5.
- Handshake: hold res_ready=0 for 10 cycles -> outputs stable, cmd_ready=0, and a second cmd_valid pulse during this time is ignored. Then res_ready=1 -> cmd_ready=1 next cycle, and a back-to-back second command completes with correct values.
